dmem_responder: RTL and testbench

- Memory-side responder for the data-memory request interface (mem_in_type / mem_out_type).
- Sits at the far end of the data path, below the store-buffering initiator, and serves its loads, stores and fences from a local word-addressed SRAM array with programmable wait states.
- Handles one outstanding request at a time; every response is a single-cycle mem_ready pulse.

---
 rtl/dmem_responder_if.sv | 22 ++
 rtl/dmem_responder.sv | 123 ++++++++++++
 tb/tb_dmem_responder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between the initiator (master) and
// the memory-side responder (slave).
interface dmem_responder_if;
  logic        mem_valid;
  logic        mem_fence;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_fence, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_fence, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/dmem_responder.sv
// Memory-side responder: serves loads/stores/fences from a local SRAM with wait states.
// Optional macro DMEM_RANDOM_WAIT_EN adds 0..3 LFSR-driven extra wait cycles per request.
module dmem_responder #(
  parameter int DEPTH         = 10,
  parameter int LATENCY       = 1,
  parameter int FENCE_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   dmem
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state, state_nxt;
  logic [4:0]         cnt, cnt_nxt;
  logic [4:0]         extra_wait;
  logic [4:0]         load_val;
  logic               capture;
  logic               ready_q;
  logic [31:0]        rdata_q;
  logic               req_fence;
  logic [DEPTH-1:0]   req_idx;
  logic [31:0]        req_wdata;
  logic [3:0]         req_wstrb;
  logic               req_load, req_store, cap_load;
  logic               rd_load;
  logic [DEPTH-1:0]   rd_idx;
  logic [31:0]        mem [0:(1<<DEPTH)-1];
  logic               unused_req_bits;

  assign unused_req_bits = ^{dmem.mem_instr, dmem.mem_addr[31:DEPTH+2], dmem.mem_addr[1:0]};

`ifdef DMEM_RANDOM_WAIT_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (!rst) lfsr <= 16'hACE1;
    else      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign extra_wait = {3'b000, lfsr[1:0]};
`else
  assign extra_wait = 5'd0;
`endif

  assign req_load  = !req_fence && !(|req_wstrb);
  assign req_store = !req_fence && (|req_wstrb);
  assign cap_load  = !dmem.mem_fence && !(|dmem.mem_wstrb);
  assign load_val  = (dmem.mem_fence ? 5'(FENCE_LATENCY - 1) : 5'(LATENCY - 1)) + extra_wait;

  // A one-cycle-latency request goes straight to RESP, so the read must come from the live request.
  assign rd_idx  = capture ? dmem.mem_addr[DEPTH+1:2] : req_idx;
  assign rd_load = capture ? cap_load : req_load;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (dmem.mem_valid) begin
          capture   = 1'b1;
          cnt_nxt   = load_val;
          state_nxt = (load_val == 5'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt <= 5'd1) begin
          cnt_nxt   = 5'd0;
          state_nxt = RESP;
        end else begin
          cnt_nxt   = cnt - 5'd1;
        end
      end
      RESP: begin
        cnt_nxt   = 5'd0;
        state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = 5'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      ready_q   <= 1'b0;
      rdata_q   <= 32'd0;
      req_fence <= 1'b0;
      req_idx   <= '0;
      req_wdata <= 32'd0;
      req_wstrb <= 4'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ready_q <= (state_nxt == RESP);
      rdata_q <= ((state_nxt == RESP) && rd_load) ? mem[rd_idx] : 32'd0;
      if (capture) begin
        req_fence <= dmem.mem_fence;
        req_idx   <= dmem.mem_addr[DEPTH+1:2];
        req_wdata <= dmem.mem_wdata;
        req_wstrb <= dmem.mem_wstrb;
      end
    end
  end

  // Store commits on the edge that ends RESP; a reset on that edge cancels it.
  always_ff @(posedge clk) begin
    if (rst && (state == RESP) && req_store) begin
      for (int i = 0; i < 4; i++) begin
        if (req_wstrb[i]) mem[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  assign dmem.mem_ready = ready_q;
  assign dmem.mem_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 1, 3, 4) share one stimulus source.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic        fence = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  wstrb = 4'd0;
  int          sel = 0;
  logic        ready_m;
  logic [31:0] rdata_m;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder_if if0 ();
  dmem_responder_if if1 ();
  dmem_responder_if if2 ();

  assign if0.mem_valid = valid && (sel == 0);
  assign if1.mem_valid = valid && (sel == 1);
  assign if2.mem_valid = valid && (sel == 2);
  assign if0.mem_fence = fence;  assign if1.mem_fence = fence;  assign if2.mem_fence = fence;
  assign if0.mem_instr = 1'b0;   assign if1.mem_instr = 1'b0;   assign if2.mem_instr = 1'b0;
  assign if0.mem_addr  = addr;   assign if1.mem_addr  = addr;   assign if2.mem_addr  = addr;
  assign if0.mem_wdata = wdata;  assign if1.mem_wdata = wdata;  assign if2.mem_wdata = wdata;
  assign if0.mem_wstrb = wstrb;  assign if1.mem_wstrb = wstrb;  assign if2.mem_wstrb = wstrb;

  dmem_responder #(.DEPTH(10), .LATENCY(1), .FENCE_LATENCY(2)) u_lat1 (.clk(clk), .rst(rst), .dmem(if0));
  dmem_responder #(.DEPTH(10), .LATENCY(3), .FENCE_LATENCY(2)) u_lat3 (.clk(clk), .rst(rst), .dmem(if1));
  dmem_responder #(.DEPTH(10), .LATENCY(4), .FENCE_LATENCY(2)) u_lat4 (.clk(clk), .rst(rst), .dmem(if2));

  always_comb begin
    ready_m = if0.mem_ready;
    rdata_m = if0.mem_rdata;
    case (sel)
      1: begin ready_m = if1.mem_ready; rdata_m = if1.mem_rdata; end
      2: begin ready_m = if2.mem_ready; rdata_m = if2.mem_rdata; end
      default: ;
    endcase
  end

  // Raises valid at the start of a cycle and returns at the negedge of the ready cycle.
  // lat counts cycles from the drive cycle to ready (-1 when no ready within budget).
  task automatic txn(input int s, input logic f, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] st, output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    sel = s; fence = f; addr = a; wdata = wd; wstrb = st; valid = 1'b1;
    lat = -1;
    rd  = 32'd0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready_m) begin
        lat = k;
        rd  = rdata_m;
        break;
      end
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    valid = 1'b0; fence = 1'b0; wstrb = 4'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({if0.mem_ready, if1.mem_ready, if2.mem_ready} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 000", {if0.mem_ready, if1.mem_ready, if2.mem_ready});
    end
    n_cmp++; if (if0.mem_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata0: got %h expected 0", if0.mem_rdata); end
    n_cmp++; if (if1.mem_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata1: got %h expected 0", if1.mem_rdata); end
    n_cmp++; if (if2.mem_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata2: got %h expected 0", if2.mem_rdata); end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({if0.mem_ready, if1.mem_ready, if2.mem_ready} !== 3'b000) begin
      n_fail++; $display("FAIL post_reset_ready: got %b expected 000", {if0.mem_ready, if1.mem_ready, if2.mem_ready});
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    int lat;
    txn(0, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat); idle();
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL st_lat: got %0d expected 1", lat); end
    n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL st_rdata: got %h expected 0", rd); end
    n_cmp++; if (ready_m !== 1'b0) begin n_fail++; $display("FAIL st_pulse: ready=%b expected 0", ready_m); end
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, lat); idle();
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL ld_lat: got %0d expected 1", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_rdata: got %h expected deadbeef", rd); end
    @(negedge clk);
    n_cmp++; if (rdata_m !== 32'd0) begin n_fail++; $display("FAIL ld_rdata_idle: got %h expected 0", rdata_m); end
  endtask

  task automatic test_byte_strobes();
    logic [31:0] rd;
    int lat;
    txn(0, 1'b0, 32'h20, 32'h11223344, 4'hF, rd, lat); idle();
    txn(0, 1'b0, 32'h20, 32'hAABBCCDD, 4'b0101, rd, lat); idle();
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, lat); idle();
    n_cmp++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL strobe_rdata: got %h expected 11bb33dd", rd); end
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL strobe_lat: got %0d expected 1", lat); end
  endtask

  task automatic test_latency();
    logic [31:0] rd;
    int lat;
    txn(1, 1'b0, 32'h44, 32'h13579BDF, 4'hF, rd, lat);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL lat3_store: got %0d expected 3", lat); end
    // Valid stays high past ready: the cycle after RESP re-captures, so the next ready is 4 cycles on.
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++; if (ready_m !== (k == 4)) begin
        n_fail++; $display("FAIL lat3_hold_k%0d: ready=%b expected %b", k, ready_m, (k == 4));
      end
    end
    idle();
    txn(1, 1'b0, 32'h44, 32'h0, 4'h0, rd, lat); idle();
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL lat3_load: got %0d expected 3", lat); end
    n_cmp++; if (rd !== 32'h13579BDF) begin n_fail++; $display("FAIL lat3_rdata: got %h expected 13579bdf", rd); end
  endtask

  task automatic test_fence();
    logic [31:0] rd;
    int lat;
    txn(0, 1'b0, 32'h40, 32'hCAFEF00D, 4'hF, rd, lat); idle();
    txn(0, 1'b1, 32'h40, 32'h55555555, 4'hF, rd, lat); idle();
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL fence_lat: got %0d expected 2", lat); end
    n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL fence_rdata: got %h expected 0", rd); end
    txn(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, lat); idle();
    n_cmp++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL fence_nowrite: got %h expected cafef00d", rd); end
  endtask

  task automatic test_aliasing();
    logic [31:0] rd;
    int lat;
    txn(0, 1'b0, 32'h0000_1004, 32'h12345678, 4'hF, rd, lat); idle();
    txn(0, 1'b0, 32'h0000_0004, 32'h0, 4'h0, rd, lat); idle();
    n_cmp++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL alias_hi: got %h expected 12345678", rd); end
    txn(0, 1'b0, 32'hF000_0007, 32'h0, 4'h0, rd, lat); idle();
    n_cmp++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL alias_lo: got %h expected 12345678", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    int lat;
    txn(0, 1'b0, 32'h30, 32'hA5A5A5A5, 4'hF, rd, lat);
    txn(0, 1'b0, 32'h30, 32'h0, 4'h0, rd, lat); idle();
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL b2b_lat: got %0d expected 1", lat); end
    n_cmp++; if (rd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL b2b_rdata: got %h expected a5a5a5a5", rd); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd;
    int lat;
    logic saw;
    txn(2, 1'b0, 32'h80, 32'h0BADCAFE, 4'hF, rd, lat); idle();
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL abort_pre_lat: got %0d expected 4", lat); end
    @(posedge clk); #1;
    sel = 2; fence = 1'b0; addr = 32'h80; wdata = 32'hFFFFFFFF; wstrb = 4'hF; valid = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin rst = 1'b0; valid = 1'b0; wstrb = 4'h0; end
      if (k == 4) rst = 1'b1;
      @(negedge clk);
      if (ready_m) saw = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++; if (saw !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got %b expected 0", saw); end
    txn(2, 1'b0, 32'h80, 32'h0, 4'h0, rd, lat); idle();
    n_cmp++; if (rd !== 32'h0BADCAFE) begin n_fail++; $display("FAIL abort_rdata: got %h expected 0badcafe", rd); end
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL abort_post_lat: got %0d expected 4", lat); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_strobes();
    test_latency();
    test_fence();
    test_aliasing();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
